multi_channel_pipeline_rr: RTL and testbench

- Parametrised successor to the two-pipeline wrapper: NUM_CH independent DEPTH-stage pipelines that share one resource (incrementer) at stage SHARED_STAGE.
- A round-robin arbiter grants the shared resource to one channel per cycle.
- A losing channel takes a channel-wide stall: its whole pipeline freezes. Other channels are unaffected.
- Sits between producer_fsm and consumer_fsm, replacing the fixed 2-channel pipeline_wrapped.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/multi_channel_pipeline_rr_if.sv | 27 ++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/multi_channel_pipeline_rr.sv | 72 +++++++
 tb/tb_multi_channel_pipeline_rr.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and the shared-resource operation for the multi-channel pipeline.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package pipe_pkg;

    localparam int DEF_NUM_CH = 2;
    localparam int DEF_WIDTH  = 32;
    localparam int MAX_WIDTH  = 64;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int PTR_W = ptr_width(DEF_NUM_CH);

    // Operates at MAX_WIDTH; callers truncate, which keeps the result mod 2^WIDTH.
    function automatic logic [MAX_WIDTH-1:0] shared_op(input logic [MAX_WIDTH-1:0] x);
        return x + MAX_WIDTH'(1);
    endfunction

endpackage

// File: rtl/multi_channel_pipeline_rr_if.sv
// Producer/consumer-facing bundle of the multi-channel pipeline, channels packed c*WIDTH.
// Latency: n/a (wiring only).
// Backpressure: stall travels slave -> master; no consumer backpressure.
interface multi_channel_pipeline_rr_if
    import pipe_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int WIDTH  = DEF_WIDTH
);
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       flush;
    logic [NUM_CH*WIDTH-1:0] out_data;
    logic [NUM_CH-1:0]       out_valid;
    logic [NUM_CH-1:0]       stall;
    logic [NUM_CH-1:0]       grant;

    modport master (
        output in_data, in_valid, flush,
        input  out_data, out_valid, stall, grant
    );

    modport slave (
        input  in_data, in_valid, flush,
        output out_data, out_valid, stall, grant
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for the shared stage; scans from ptr, ptr moves past the winner.
// Latency: grant is combinational from req; pointer updates on the next edge.
// Backpressure: losers are simply not granted; the caller turns that into a stall.
module rr_arbiter
    import pipe_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int PW     = PTR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] grant
);
    logic [PW-1:0] ptr;
    logic [PW-1:0] idx;
    logic [PW-1:0] gidx;
    logic          found;

    always_comb begin
        grant = '0;
        idx   = '0;
        gidx  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = PW'((int'(ptr) + i) % NUM_CH);
            if (!found && req[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
        if (found) begin
            grant[gidx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= PW'((int'(gidx) + 1) % NUM_CH);
        end
    end
endmodule

// File: rtl/multi_channel_pipeline_rr.sv
// NUM_CH independent DEPTH-stage pipelines sharing one incrementer at SHARED_STAGE.
// Latency: DEPTH cycles uncontended, +1 per lost arbitration.
// Backpressure: a channel losing arbitration freezes entirely and raises stall to its producer.
module multi_channel_pipeline_rr
    import pipe_pkg::*;
#(
    parameter int NUM_CH       = DEF_NUM_CH,
    parameter int WIDTH        = DEF_WIDTH,
    parameter int DEPTH        = 4,
    parameter int SHARED_STAGE = 2
) (
    input logic                        clk,
    input logic                        reset,
    multi_channel_pipeline_rr_if.slave bus
);
    if (SHARED_STAGE < 1 || SHARED_STAGE > DEPTH - 1) begin : g_bad_stage
        $error("multi_channel_pipeline_rr: SHARED_STAGE must lie in 1..DEPTH-1");
    end
    if (NUM_CH < 1 || WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_size
        $error("multi_channel_pipeline_rr: NUM_CH >= 1 and 1 <= WIDTH <= MAX_WIDTH required");
    end

    logic [NUM_CH-1:0]       req;
    logic [NUM_CH-1:0]       grant_w;
    logic [NUM_CH-1:0]       stall_w;
    logic [NUM_CH-1:0]       out_valid_w;
    logic [NUM_CH*WIDTH-1:0] out_data_w;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .PW     (ptr_width(NUM_CH))
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .grant (grant_w)
    );

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DEPTH-1:0] vld;
        logic [WIDTH-1:0] dat [DEPTH];

        // A flushing channel withdraws its request so the slot can go elsewhere.
        assign req[c]         = vld[SHARED_STAGE-1] & ~bus.flush[c];
        assign stall_w[c]     = req[c] & ~grant_w[c];
        assign out_valid_w[c] = vld[DEPTH-1] & ~stall_w[c] & ~bus.flush[c];
        assign out_data_w[c*WIDTH +: WIDTH] = dat[DEPTH-1];

        always_ff @(posedge clk) begin
            if (reset) begin
                vld <= '0;
                for (int s = 0; s < DEPTH; s++) begin
                    dat[s] <= '0;
                end
            end else if (bus.flush[c]) begin
                vld <= '0;
            end else if (!stall_w[c]) begin
                vld    <= {vld[DEPTH-2:0], bus.in_valid[c]};
                dat[0] <= bus.in_data[c*WIDTH +: WIDTH];
                for (int s = 1; s < DEPTH; s++) begin
                    dat[s] <= (s == SHARED_STAGE) ? WIDTH'(shared_op(MAX_WIDTH'(dat[s-1])))
                                                  : dat[s-1];
                end
            end
        end
    end

    assign bus.grant     = grant_w;
    assign bus.stall     = stall_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_data  = out_data_w;
endmodule

// File: tb/tb_multi_channel_pipeline_rr.sv
// Directed bench for multi_channel_pipeline_rr at NUM_CH=2, DEPTH=4, SHARED_STAGE=2.
module tb_multi_channel_pipeline_rr;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multi_channel_pipeline_rr_if #(.NUM_CH(2), .WIDTH(32)) bus ();

    multi_channel_pipeline_rr #(
        .NUM_CH       (2),
        .WIDTH        (32),
        .DEPTH        (4),
        .SHARED_STAGE (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] od(input int c);
        return bus.out_data[c*32 +: 32];
    endfunction

    task automatic drive(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [1:0] f);
        bus.in_valid = v;
        bus.in_data  = {d1, d0};
        bus.flush    = f;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        drive(2'b00, 32'h0, 32'h0, 2'b00);
        next_cycle();
        reset = 1'b0;
    endtask

    logic [31:0] nxt [2];
    logic [31:0] expv [2];
    int          acc [2];
    int          outs [2];

    initial begin
        // Reset held three cycles
        reset = 1'b1;
        drive(2'b00, 32'h0, 32'h0, 2'b00);
        repeat (3) next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 2'b00);
        chk("rst_stall", bus.stall, 2'b00);
        chk("rst_grant", bus.grant, 2'b00);
        chk("rst_data0", od(0), 32'h0);
        chk("rst_data1", od(1), 32'h0);
        next_cycle();

        // Single ch0 item, ch1 idle
        drive(2'b01, 32'h10, 32'h0, 2'b00);
        for (int k = 0; k < 6; k++) begin
            if (k == 1) drive(2'b00, 32'h0, 32'h0, 2'b00);
            @(negedge clk);
            chk("single_out_valid", bus.out_valid, (k == 4) ? 2'b01 : 2'b00);
            chk("single_grant", bus.grant, (k == 2) ? 2'b01 : 2'b00);
            chk("single_stall", bus.stall, 2'b00);
            if (k == 4) chk("single_data0", od(0), 32'h11);
            next_cycle();
        end

        // Both channels in the same cycle: ch0 wins, ch1 one cycle late
        apply_reset();
        drive(2'b11, 32'h0A, 32'h0B, 2'b00);
        for (int k = 0; k < 7; k++) begin
            if (k == 1) drive(2'b00, 32'h0, 32'h0, 2'b00);
            @(negedge clk);
            chk("contend_grant", bus.grant, (k == 2) ? 2'b01 : (k == 3) ? 2'b10 : 2'b00);
            chk("contend_stall", bus.stall, (k == 2) ? 2'b10 : 2'b00);
            chk("contend_out_valid", bus.out_valid,
                (k == 4) ? 2'b01 : (k == 5) ? 2'b10 : 2'b00);
            if (k == 4) chk("contend_data0", od(0), 32'h0B);
            if (k == 5) chk("contend_data1", od(1), 32'h0C);
            next_cycle();
        end

        // Both channels streaming 0,1,2,... for 20 cycles, producer honours stall
        apply_reset();
        for (int c = 0; c < 2; c++) begin
            nxt[c] = 32'h0; expv[c] = 32'h1; acc[c] = 0; outs[c] = 0;
        end
        for (int cyc = 0; cyc < 34; cyc++) begin
            drive((cyc < 20) ? 2'b11 : 2'b00, nxt[0], nxt[1], 2'b00);
            @(negedge clk);
            for (int c = 0; c < 2; c++) begin
                if (bus.out_valid[c]) begin
                    chk("stream_data", od(c), expv[c]);
                    expv[c] = expv[c] + 32'h1;
                    outs[c]++;
                end
            end
            if (cyc < 2) chk("stream_grant_fill", bus.grant, 2'b00);
            else if (cyc < 20) chk("stream_grant_alt", bus.grant, (cyc % 2 == 0) ? 2'b01 : 2'b10);
            for (int c = 0; c < 2; c++) begin
                if (bus.in_valid[c] && !bus.stall[c]) begin
                    nxt[c] = nxt[c] + 32'h1;
                    acc[c]++;
                end
            end
            next_cycle();
        end
        chk("stream_acc0", acc[0], 11);
        chk("stream_acc1", acc[1], 11);
        chk("stream_outs0", outs[0], acc[0]);
        chk("stream_outs1", outs[1], acc[1]);

        // Flush ch1 while it is stalled behind ch0
        apply_reset();
        for (int k = 0; k < 11; k++) begin
            case (k)
                0:       drive(2'b11, 32'h20, 32'h40, 2'b00);
                1:       drive(2'b11, 32'h21, 32'h41, 2'b00);
                2:       drive(2'b11, 32'h22, 32'h42, 2'b10);
                5:       drive(2'b10, 32'h0, 32'h50, 2'b00);
                default: drive(2'b00, 32'h0, 32'h0, 2'b00);
            endcase
            @(negedge clk);
            chk("flush_stall", bus.stall, 2'b00);
            chk("flush_grant", bus.grant,
                (k >= 2 && k <= 4) ? 2'b01 : (k == 7) ? 2'b10 : 2'b00);
            chk("flush_out_valid", bus.out_valid,
                (k >= 4 && k <= 6) ? 2'b01 : (k == 9) ? 2'b10 : 2'b00);
            if (k == 4) chk("flush_data0_a", od(0), 32'h21);
            if (k == 5) chk("flush_data0_b", od(0), 32'h22);
            if (k == 6) chk("flush_data0_c", od(0), 32'h23);
            if (k == 9) chk("flush_data1", od(1), 32'h51);
            next_cycle();
        end

        // Reset with ch0 full and the pointer parked on ch1
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            drive(2'b01, 32'h70 + 32'(k), 32'h0, 2'b00);
            next_cycle();
        end
        drive(2'b00, 32'h0, 32'h0, 2'b00);
        @(negedge clk);
        chk("pre_rst_out_valid", bus.out_valid, 2'b01);
        chk("pre_rst_data0", od(0), 32'h71);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", bus.out_valid, 2'b00);
        chk("mid_rst_stall", bus.stall, 2'b00);
        chk("mid_rst_grant", bus.grant, 2'b00);
        chk("mid_rst_data0", od(0), 32'h0);
        chk("mid_rst_data1", od(1), 32'h0);
        next_cycle();
        drive(2'b11, 32'h5, 32'h5, 2'b00);
        for (int k = 0; k < 7; k++) begin
            if (k == 1) drive(2'b00, 32'h0, 32'h0, 2'b00);
            @(negedge clk);
            chk("post_rst_grant", bus.grant, (k == 2) ? 2'b01 : (k == 3) ? 2'b10 : 2'b00);
            chk("post_rst_stall", bus.stall, (k == 2) ? 2'b10 : 2'b00);
            chk("post_rst_out_valid", bus.out_valid,
                (k == 4) ? 2'b01 : (k == 5) ? 2'b10 : 2'b00);
            if (k == 4) chk("post_rst_data0", od(0), 32'h6);
            if (k == 5) chk("post_rst_data1", od(1), 32'h6);
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
